// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern-generator controller.
// BIST_ALLZERO_EN selects the 8-pattern de Bruijn variant.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [2:0] LFSR_SEED = 3'b001;

  localparam logic [3:0] GOLDEN_SIG_BASE    = 4'b0110;
  localparam logic [3:0] GOLDEN_SIG_ALLZERO = 4'b1100;

`ifdef BIST_ALLZERO_EN
  localparam int         N_PATTERNS     = 8;
  localparam logic [3:0] GOLDEN_DEFAULT = GOLDEN_SIG_ALLZERO;
`else
  localparam int         N_PATTERNS     = 7;
  localparam logic [3:0] GOLDEN_DEFAULT = GOLDEN_SIG_BASE;
`endif

  localparam logic [3:0] CNT_LAST = 4'(N_PATTERNS - 1);

endpackage

// File: rtl/bist_lfsr3.sv
// 3-bit pattern LFSR; BIST_ALLZERO_EN splices 000 in after 100.
// Reset and load both return the register to the seed.
module bist_lfsr3
  import bist_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [2:0] q
);

  logic f;

  always_comb begin
    f = q[2] ^ q[1];
`ifdef BIST_ALLZERO_EN
    f = f ^ (q[1:0] == 2'b00);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= {q[1:0], f};
    end
  end

endmodule

// File: rtl/bist_tpg_ctrl.sv
// BIST controller: sequences LFSR patterns into the CUT and grades the MISR.
// BIST_ALLZERO_EN adds the all-zero pattern (N=8, alternate golden).
module bist_tpg_ctrl
  import bist_pkg::*;
#(
  parameter logic [3:0] GOLDEN_SIG = GOLDEN_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] tpg_out,
  output logic       ora_reset_n,
  input  logic [3:0] ora_sig,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] pattern_count,
  output logic [3:0] sig_capt
);

  state_t     state;
  state_t     next;
  logic [2:0] q;
  logic       load;
  logic       step;

  assign load = (state == S_CLEAR);
  assign step = (state == S_RUN);

  bist_lfsr3 u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (step),
    .q     (q)
  );

  always_comb begin
    next    = state;
    busy    = 1'b0;
    done    = 1'b0;
    tpg_out = 3'b000;
    unique case (state)
      S_IDLE: begin
        if (start) next = S_CLEAR;
      end
      S_CLEAR: begin
        busy = 1'b1;
        next = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        tpg_out = q;
        if (pattern_count == CNT_LAST) next = S_COMPARE;
      end
      S_COMPARE: begin
        busy = 1'b1;
        next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) next = S_CLEAR;
      end
      default: next = S_IDLE;
    endcase
  end

  // ora_reset_n is registered from next so the MISR clear is glitch-free
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      ora_reset_n   <= 1'b0;
      pass          <= 1'b0;
      sig_capt      <= 4'b0000;
      pattern_count <= 4'd0;
    end else begin
      state       <= next;
      ora_reset_n <= !((next == S_IDLE) || (next == S_CLEAR));
      if (next == S_CLEAR) begin
        pass          <= 1'b0;
        pattern_count <= 4'd0;
      end else if (state == S_RUN) begin
        pattern_count <= pattern_count + 4'd1;
      end
      if (state == S_COMPARE) begin
        sig_capt <= ora_sig;
        pass     <= (ora_sig == GOLDEN_SIG);
      end
    end
  end

endmodule

// File: doc/bist_tpg_ctrl.md
BIST_TPG_CTRL -- requirements
Module: bist_tpg_ctrl

Interface
REQ-001 SHALL have parameter GOLDEN_SIG, 4 bits, default 4'b0110 (macro absent) or 4'b1100 (BIST_ALLZERO_EN defined), fault-free MISR signature.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port start  in  1  level-sampled test request.
REQ-005 SHALL have port tpg_out  out  3  CUT stimulus {a,b,cin}; bit2=a, bit0=cin.
REQ-006 SHALL have port ora_reset_n  out  1  clear for the downstream MISR; 0 clears.
REQ-007 SHALL have port ora_sig  in  4  MISR signature, bit3 = MISR stage 4.
REQ-008 SHALL have ports busy, done, pass  out  1 each  status flags.
REQ-009 SHALL have port pattern_count  out  4  patterns applied in the current run.
REQ-010 SHALL have port sig_capt  out  4  signature captured at COMPARE.

Function
REQ-011 SHALL use FSM states IDLE, CLEAR, RUN, COMPARE, DONE.
REQ-012 IDLE: start=1 -> CLEAR; otherwise stay.
REQ-013 CLEAR lasts exactly 1 cycle -> RUN; LFSR loaded with seed 3'b001 on the CLEAR->RUN edge; pattern_count cleared.
REQ-014 RUN lasts exactly N cycles (N=7, or 8 with BIST_ALLZERO_EN); tpg_out = LFSR state; LFSR steps and pattern_count increments every RUN cycle; -> COMPARE on the edge where pattern_count reaches N.
REQ-015 LFSR step: f = q[2]^q[1]; next = {q[1], q[0], f}; base sequence 001,010,101,011,111,110,100, repeat.
REQ-016 COMPARE lasts exactly 1 cycle: on its exit edge sig_capt <= ora_sig and pass <= (ora_sig == GOLDEN_SIG); -> DONE.
REQ-017 DONE: done=1 and pass/sig_capt held; start=1 -> CLEAR (rerun); otherwise stay.
REQ-018 busy SHALL be 1 exactly in CLEAR, RUN and COMPARE; start SHALL be ignored while busy.
REQ-019 ora_reset_n SHALL be flop-driven, 0 exactly in cycles where state is IDLE or CLEAR, else 1.
REQ-020 tpg_out SHALL be 3'b000 outside RUN.
REQ-021 done and pass SHALL clear on the edge entering CLEAR.
REQ-022 Start sampled at edge t: first pattern on tpg_out in cycle t+2; done=1 from cycle t+N+3.

Reset
REQ-023 reset=0 at a rising edge SHALL force IDLE, tpg_out=0, ora_reset_n=0, busy=0, done=0, pass=0, pattern_count=0, sig_capt=0, LFSR=3'b001, from any state including mid-RUN.
REQ-024 reset SHALL take priority over start in the same cycle.

Configuration
REQ-025 Macro BIST_ALLZERO_EN defined: LFSR feedback becomes f ^ (q[1:0]==2'b00), inserting 000 after 100 (8-pattern de Bruijn sequence ending in 000), N=8, GOLDEN_SIG default 4'b1100.
REQ-026 Macro absent: pure maximal-length LFSR, 7 patterns, no all-zero pattern, N=7, GOLDEN_SIG default 4'b0110.

Structure
REQ-027 Package bist_pkg SHALL hold the FSM state enum, LFSR seed 3'b001, N_PATTERNS and both default golden signatures, each selected by BIST_ALLZERO_EN.
REQ-028 LFSR SHALL be a sub-module bist_lfsr3 (ports clock, reset, load, step, q[2:0]); FSM, counter and compare stay in bist_tpg_ctrl.

Verification
REQ-029 Macro absent, controller wired to a fault-free full adder and the 4-bit MISR, start pulse -> tpg_out 001,010,101,011,111,110,100 in cycles t+2..t+8; done=1 at t+10; pass=1; sig_capt=4'b0110.
REQ-030 BIST_ALLZERO_EN, same wiring -> 8 patterns ending 100,000; pattern_count=8; sig_capt=4'b1100; pass=1.
REQ-031 Sum output stuck-at-0 injected -> sig_capt != 4'b0110; pass=0; done=1.
REQ-032 reset=0 asserted during the 4th RUN cycle -> next cycle all outputs at reset values, state IDLE; a later start produces a full, correct run.
REQ-033 start held high through RUN -> no restart; in DONE, start=1 -> CLEAR with ora_reset_n=0, done=0, pass=0 for that cycle, followed by an identical second run.
REQ-034 ora_sig forced to 4'b1111 during COMPARE -> pass=0, sig_capt=4'b1111.
